// File: rtl/ahblite_pkg.sv
// ahblite_pkg: shared AHB-Lite codes, default SoC memory map and default-slave state type
package ahblite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] BASE_RAMCODE = 32'h0000_0000;
    localparam logic [31:0] BASE_RAMDATA = 32'h2000_0000;
    localparam logic [31:0] BASE_LCD     = 32'h4005_0000;
    localparam logic [31:0] BASE_UART    = 32'h4000_0010;
    localparam logic [31:0] BASE_CAMERA  = 32'h4030_0000;
    localparam logic [31:0] BASE_BUZZER  = 32'h4010_0000;

    localparam logic [31:0] MASK_RAMCODE = 32'hFFFF_0000;
    localparam logic [31:0] MASK_RAMDATA = 32'hFFFF_0000;
    localparam logic [31:0] MASK_LCD     = 32'hFFFF_0000;
    localparam logic [31:0] MASK_UART    = 32'hFFFF_FFF0;
    localparam logic [31:0] MASK_CAMERA  = 32'hFFF0_0000;
    localparam logic [31:0] MASK_BUZZER  = 32'hFFF0_0000;

    localparam logic [6*32-1:0] DEFAULT_BASE = {BASE_BUZZER, BASE_CAMERA, BASE_UART,
                                                BASE_LCD, BASE_RAMDATA, BASE_RAMCODE};
    localparam logic [6*32-1:0] DEFAULT_MASK = {MASK_BUZZER, MASK_CAMERA, MASK_UART,
                                                MASK_LCD, MASK_RAMDATA, MASK_RAMCODE};
    localparam logic [5:0]      DEFAULT_PORT_EN = 6'b011111;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave: two-cycle ERROR responder for unmapped transfers plus error-capture registers
module ahblite_default_slave
    import ahblite_pkg::*;
#(
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         haddr,
    input  logic [1:0]          htrans,
    input  logic                unmapped,
    input  logic                hready,
    output logic                ready,
    output logic                resp,
    output logic [31:0]         err_addr,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic                err_pulse
);

    ds_state_t state, next;
    logic      req;
    logic      capture;

    assign req     = unmapped && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign capture = (next == DS_ERR1) && (state != DS_ERR1);

    // State register for the error-response sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DS_IDLE;
        else        state <= next;
    end

    // ERR1 stalls the master with ERROR, ERR2 completes it; ERR2 may chain straight into a new error
    always_comb begin
        next  = state;
        ready = 1'b1;
        resp  = HRESP_OKAY;
        case (state)
            DS_IDLE: next = req ? DS_ERR1 : DS_IDLE;
            DS_ERR1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
                next  = DS_ERR2;
            end
            DS_ERR2: begin
                resp = HRESP_ERROR;
                next = req ? DS_ERR1 : DS_IDLE;
            end
            default: next = DS_IDLE;
        endcase
    end

    // Record the offending address and count each unmapped access once, saturating the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr  <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= capture;
            if (capture) begin
                err_addr <= haddr;
                err_cnt  <= &err_cnt ? err_cnt : err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahblite_addr_decoder_mux.sv
// ahblite_addr_decoder_mux: N-port AHB-Lite address decoder with data-phase response mux and default slave
module ahblite_addr_decoder_mux
    import ahblite_pkg::*;
#(
    parameter int                   NPORT    = 6,
    parameter logic [NPORT*32-1:0]  BASE     = DEFAULT_BASE,
    parameter logic [NPORT*32-1:0]  MASK     = DEFAULT_MASK,
    parameter logic [NPORT-1:0]     PORT_EN  = DEFAULT_PORT_EN,
    parameter int                   ERRCNT_W = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    output logic [NPORT-1:0]      HSEL,
    input  logic [NPORT*32-1:0]   HRDATA_S,
    input  logic [NPORT-1:0]      HREADYOUT_S,
    input  logic [NPORT-1:0]      HRESP_S,
    output logic [31:0]           HRDATA,
    output logic                  HREADY,
    output logic                  HRESP,
    output logic [31:0]           ERR_ADDR,
    output logic [ERRCNT_W-1:0]   ERR_CNT,
    output logic                  ERR_PULSE
);

    logic [NPORT-1:0] match;
    logic [NPORT:0]   dsel;
    logic             ds_ready;
    logic             ds_resp;

    // Compare the address against every enabled window
    always_comb begin
        match = '0;
        for (int i = 0; i < NPORT; i++)
            match[i] = PORT_EN[i] && ((HADDR & MASK[i*32 +: 32]) == (BASE[i*32 +: 32] & MASK[i*32 +: 32]));
    end

    // Isolating the lowest set bit gives lowest-index priority on overlapping windows
    assign HSEL = match & (-match);

    // Data-phase owner; bit NPORT is the default slave, held while the current transfer is stalled
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)    dsel <= '0;
        else if (HREADY) dsel <= {~|match, HSEL};
    end

    // Route the owning slave back to the master; no owner or default owner uses the default slave
    always_comb begin
        HRDATA = '0;
        HREADY = ds_ready;
        HRESP  = ds_resp;
        for (int i = 0; i < NPORT; i++) begin
            if (dsel[i]) begin
                HRDATA = HRDATA_S[i*32 +: 32];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

    ahblite_default_slave #(
        .ERRCNT_W(ERRCNT_W)
    ) u_default_slave (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .haddr    (HADDR),
        .htrans   (HTRANS),
        .unmapped (~|match),
        .hready   (HREADY),
        .ready    (ds_ready),
        .resp     (ds_resp),
        .err_addr (ERR_ADDR),
        .err_cnt  (ERR_CNT),
        .err_pulse(ERR_PULSE)
    );

endmodule

// File: tb/tb_ahblite_addr_decoder_mux.sv
// tb_ahblite_addr_decoder_mux: directed and randomized checks of decode, response mux and default slave
module tb_ahblite_addr_decoder_mux;
    import ahblite_pkg::*;

    localparam int N = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     haddr;
    logic [1:0]      htrans;
    logic [N-1:0]    hsel;
    logic [N*32-1:0] hrdata_s;
    logic [N-1:0]    hreadyout_s;
    logic [N-1:0]    hresp_s;
    logic [31:0]     hrdata;
    logic            hready;
    logic            hresp;
    logic [31:0]     err_addr;
    logic [7:0]      err_cnt;
    logic            err_pulse;

    logic [31:0]  bases [N] = '{32'h0000_0000, 32'h2000_0000, 32'h4005_0000,
                                32'h4000_0010, 32'h4030_0000, 32'h4010_0000};
    logic [31:0]  masks [N] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                32'hFFFF_FFF0, 32'hFFF0_0000, 32'hFFF0_0000};
    logic [N-1:0] en = 6'b011111;

    int total = 0;
    int bad = 0;

    // Reference model: who owns the data phase, how many error cycles remain, error log
    int          m_owner;
    int          m_err_left;
    int          m_cnt;
    logic [31:0] m_addr;
    logic        m_pulse;

    ahblite_addr_decoder_mux #(.NPORT(N)) dut (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel),
        .HRDATA_S(hrdata_s), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp),
        .ERR_ADDR(err_addr), .ERR_CNT(err_cnt), .ERR_PULSE(err_pulse)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if (en[i] && ((a ^ bases[i]) & masks[i]) == 32'h0) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_hsel();
        int d = decode(haddr);
        return d < 0 ? '0 : N'(1) << d;
    endfunction

    function automatic logic exp_ready();
        if (m_owner >= 0 && m_owner < N) return hreadyout_s[m_owner];
        return m_err_left != 2;
    endfunction

    function automatic logic exp_resp();
        if (m_owner >= 0 && m_owner < N) return hresp_s[m_owner];
        return m_err_left != 0;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (m_owner >= 0 && m_owner < N) return hrdata_s[m_owner*32 +: 32];
        return 32'h0;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_err_left = 0;
        m_cnt = 0;
        m_addr = 32'h0;
        m_pulse = 1'b0;
    endfunction

    function automatic void model_step(input logic h);
        int d = decode(haddr);
        m_pulse = 1'b0;
        if (h) begin
            m_owner = d < 0 ? N : d;
            m_err_left = 0;
            if (d < 0 && htrans[1]) begin
                m_err_left = 2;
                m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
                m_addr = haddr;
                m_pulse = 1'b1;
            end
        end else if (m_err_left == 2) begin
            m_err_left = 1;
        end
    endfunction

    task automatic tick();
        logic h = exp_ready();
        @(posedge clk);
        model_step(h);
        @(negedge clk);
    endtask

    task automatic set_slave(input int i, input logic rdy, input logic rsp, input logic [31:0] d);
        hreadyout_s[i] = rdy;
        hresp_s[i] = rsp;
        hrdata_s[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        haddr = 32'h2000_0004;
        htrans = HTRANS_IDLE;
        for (int i = 0; i < N; i++) set_slave(i, 1'b1, 1'b0, 32'h1000_0000 + i);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        total++; if (hsel !== 6'b000010) begin bad++; $display("FAIL reset_hsel got=%b want=%b", hsel, 6'b000010); end
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL reset_hready got=%b want=1", hready); end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL reset_hresp got=%b want=0", hresp); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h want=0", hrdata); end
        total++; if (err_cnt !== 8'h0 || err_addr !== 32'h0 || err_pulse !== 1'b0) begin
            bad++; $display("FAIL reset_err cnt=%h addr=%h pulse=%b want all zero", err_cnt, err_addr, err_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramdata_read();
        haddr = 32'h2000_0010;
        htrans = HTRANS_NONSEQ;
        #1;
        total++; if (hsel !== 6'b000010 || hready !== 1'b1) begin bad++; $display("FAIL rd_addr hsel=%b hready=%b want 000010/1", hsel, hready); end
        tick();
        haddr = 32'h0000_0000;
        htrans = HTRANS_IDLE;
        set_slave(1, 1'b0, 1'b0, 32'h1111_1111);
        set_slave(0, 1'b1, 1'b0, 32'h2222_2222);
        for (int w = 0; w < 2; w++) begin
            #1;
            total++; if (hready !== 1'b0 || hrdata !== 32'h1111_1111) begin
                bad++; $display("FAIL rd_wait%0d hready=%b hrdata=%h want 0/11111111", w, hready, hrdata);
            end
            tick();
        end
        set_slave(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_data hready=%b hresp=%b hrdata=%h want 1/0/deadbeef", hready, hresp, hrdata);
        end
        tick();
    endtask

    task automatic test_disabled_port();
        haddr = 32'h4010_0000;
        htrans = HTRANS_NONSEQ;
        #1;
        total++; if (hsel !== 6'b0) begin bad++; $display("FAIL dis_hsel got=%b want=000000", hsel); end
        tick();
        haddr = 32'h2000_0000;
        htrans = HTRANS_IDLE;
        #1;
        total++; if (hready !== 1'b0 || hresp !== 1'b1) begin bad++; $display("FAIL dis_err1 hready=%b hresp=%b want 0/1", hready, hresp); end
        total++; if (err_addr !== 32'h4010_0000 || err_cnt !== 8'd1 || err_pulse !== 1'b1) begin
            bad++; $display("FAIL dis_capture addr=%h cnt=%0d pulse=%b want 40100000/1/1", err_addr, err_cnt, err_pulse);
        end
        tick();
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b1 || err_pulse !== 1'b0) begin
            bad++; $display("FAIL dis_err2 hready=%b hresp=%b pulse=%b want 1/1/0", hready, hresp, err_pulse);
        end
        tick();
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b0) begin bad++; $display("FAIL dis_after hready=%b hresp=%b want 1/0", hready, hresp); end
        tick();
    endtask

    task automatic test_uart();
        haddr = 32'h4000_0014;
        htrans = HTRANS_NONSEQ;
        #1;
        total++; if (hsel !== 6'b001000) begin bad++; $display("FAIL uart_hit got=%b want=001000", hsel); end
        tick();
        haddr = 32'h4000_0020;
        #1;
        total++; if (hsel !== 6'b0 || hready !== 1'b1) begin bad++; $display("FAIL uart_miss hsel=%b hready=%b want 000000/1", hsel, hready); end
        tick();
        haddr = 32'h4000_0014;
        htrans = HTRANS_IDLE;
        #1;
        total++; if (hready !== 1'b0 || hresp !== 1'b1) begin bad++; $display("FAIL uart_err1 hready=%b hresp=%b want 0/1", hready, hresp); end
        tick();
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b1) begin bad++; $display("FAIL uart_err2 hready=%b hresp=%b want 1/1", hready, hresp); end
        tick();
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b0 || err_cnt !== 8'd2) begin
            bad++; $display("FAIL uart_after hready=%b hresp=%b cnt=%0d want 1/0/2", hready, hresp, err_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        htrans = HTRANS_NONSEQ;
        for (int k = 0; k < 300; k++) begin
            haddr = {4'h5, 28'($urandom)};
            #1;
            total++; if (hready !== exp_ready() || hresp !== exp_resp()) begin
                bad++; $display("FAIL b2b_addr%0d hready=%b hresp=%b want %b/%b", k, hready, hresp, exp_ready(), exp_resp());
            end
            tick();
            #1;
            total++; if (hready !== 1'b0 || hresp !== 1'b1 || err_cnt !== 8'(m_cnt) || err_addr !== m_addr || err_pulse !== 1'b1) begin
                bad++; $display("FAIL b2b_err%0d hready=%b hresp=%b cnt=%0d addr=%h pulse=%b want 0/1/%0d/%h/1",
                                k, hready, hresp, err_cnt, err_addr, err_pulse, m_cnt, m_addr);
            end
            tick();
        end
        haddr = 32'h6000_0000;
        htrans = HTRANS_IDLE;
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b1) begin bad++; $display("FAIL b2b_last_err2 hready=%b hresp=%b want 1/1", hready, hresp); end
        tick();
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b0 || err_pulse !== 1'b0) begin
            bad++; $display("FAIL b2b_idle hready=%b hresp=%b pulse=%b want 1/0/0", hready, hresp, err_pulse);
        end
        total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL b2b_saturate got=%h want=ff", err_cnt); end
        tick();
    endtask

    task automatic test_reset_err1();
        haddr = 32'h7000_0000;
        htrans = HTRANS_NONSEQ;
        #1;
        tick();
        htrans = HTRANS_IDLE;
        #1;
        total++; if (hready !== 1'b0) begin bad++; $display("FAIL rst_err1_pre hready=%b want 0", hready); end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b0 || err_cnt !== 8'h0 || err_pulse !== 1'b0) begin
            bad++; $display("FAIL rst_err1_async hready=%b hresp=%b cnt=%h pulse=%b want 1/0/0/0", hready, hresp, err_cnt, err_pulse);
        end
        @(negedge clk);
        #1;
        total++; if (hready !== 1'b1 || hresp !== 1'b0 || err_cnt !== 8'h0 || err_addr !== 32'h0) begin
            bad++; $display("FAIL rst_err1_next hready=%b hresp=%b cnt=%h addr=%h want 1/0/0/0", hready, hresp, err_cnt, err_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int sel = $urandom_range(0, 3);
            int p = $urandom_range(0, N - 1);
            logic [80:0] got;
            logic [80:0] want;
            haddr = sel < 2 ? (bases[p] | ($urandom & ~masks[p])) : $urandom;
            htrans = 2'($urandom);
            for (int i = 0; i < N; i++)
                set_slave(i, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom);
            #1;
            got = {hsel, hready, hresp, hrdata, err_addr, err_cnt, err_pulse};
            want = {exp_hsel(), exp_ready(), exp_resp(), exp_rdata(), m_addr, 8'(m_cnt), m_pulse};
            total++; if (got !== want) begin
                bad++; $display("FAIL random_cycle%0d haddr=%h htrans=%b got=%h want=%h", c, haddr, htrans, got, want);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ramdata_read();
        test_disabled_port();
        test_uart();
        test_back_to_back();
        test_reset_err1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
